seq_detect_ctrl: RTL
====================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, 2, number of cycles det_clr_n is held low before arming (range 1..15).
REQ-002 Parameter CNT_W, 8, width of the target and hit counters.
REQ-003 Parameter WIN_W, 16, width of the detection-window timer.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port cfg_valid / cfg_ready, input / output, 1 each, configuration handshake.
REQ-007 Port cfg_m, input, 5, number of consecutive sequences required per detection.
REQ-008 Port cfg_n, input, 6, group length per sequence.
REQ-009 Port cfg_target, input, CNT_W, number of detections to collect; 0 means 1.
REQ-010 Port cfg_window, input, WIN_W, timeout budget in cycles while armed.
REQ-011 Port start / abort, input, 1 each, run request and cancel request.
REQ-012 Port data_in, input, 1, serial stream from the line.
REQ-013 Port det_data / det_clr_n, output, 1 each, gated stream and active-low synchronous clear to the detector.
REQ-014 Port det_m / det_n, output, 5 / 6, active configuration to the detector.
REQ-015 Port det_pulse, input, 1, single-cycle detection from the detector.
REQ-016 Port busy, done, timeout, cfg_err, output, 1 each; done, timeout and cfg_err are single-cycle pulses.
REQ-017 Port hit_cnt, output, CNT_W, detections counted in the current run.

Function
REQ-018 The FSM SHALL have states IDLE, FLUSH, ARMED and DONE.
REQ-019 cfg_ready SHALL be 1 only in IDLE; config is captured on cfg_valid & cfg_ready.
REQ-020 A config with cfg_m == 0 or cfg_n == 0 SHALL be discarded, with cfg_err pulsed the next cycle.
REQ-021 In IDLE, start SHALL move the FSM to FLUSH, clear hit_cnt, and load the window timer.
REQ-022 If a valid config and start occur in the same cycle, the run SHALL use the new config.
REQ-023 In FLUSH, det_clr_n SHALL be 0 and det_data 0 for exactly FLUSH_CYCLES cycles, then the FSM enters ARMED.
REQ-024 In ARMED, det_data SHALL equal data_in (combinational pass); in every other state det_data SHALL be 0.
REQ-025 Each det_pulse in ARMED SHALL increment hit_cnt, saturating at all-ones; det_pulse outside ARMED SHALL be ignored.
REQ-026 When hit_cnt reaches the effective target, the FSM SHALL go to DONE, pulse done for one cycle, and return to IDLE the next cycle; hit_cnt holds until the next start.
REQ-027 busy SHALL be 1 in FLUSH, ARMED and DONE.
REQ-028 det_m and det_n SHALL always reflect the captured config.
REQ-029 abort in any non-IDLE state SHALL return the FSM to IDLE next cycle, drive det_clr_n low for one cycle, and assert neither done nor timeout.
REQ-030 If abort and the final det_pulse coincide, abort SHALL win.
REQ-031 start while busy SHALL be ignored.

Reset
REQ-032 On rst_n low, the FSM SHALL be in IDLE, with cfg_ready 1, det_clr_n 0, and det_data, done, timeout, cfg_err, busy and hit_cnt all 0.
REQ-033 On rst_n low, the captured config SHALL reset to M=4, N=3, target=1, window=all-ones.
REQ-034 Reset mid-run SHALL abandon the run with no done or timeout pulse.

Configuration
REQ-035 With SEQ_CTRL_TIMEOUT_EN defined, the window timer SHALL decrement each ARMED cycle.
REQ-036 When the window timer reaches 0 in ARMED, the block SHALL pulse timeout and return to IDLE.
REQ-037 If the final det_pulse and expiry coincide, done SHALL win; cfg_window == 0 SHALL disable the timeout.
REQ-038 Without SEQ_CTRL_TIMEOUT_EN, no timer SHALL exist, timeout SHALL be tied to 0, and cfg_window SHALL be ignored.

Structure
REQ-039 Package seq_ctrl_pkg SHALL hold the state enum, the default M/N/target constants, and the cfg_m/cfg_n widths.
REQ-040 The window timer SHALL be sub-module seq_win_timer (load, enable, expired), instantiated only under SEQ_CTRL_TIMEOUT_EN.

Verification
REQ-041 Reset then start with no cfg -> det_m=4, det_n=3, FLUSH 2 cycles with det_clr_n=0, one det_pulse -> done pulse, hit_cnt=1.
REQ-042 cfg M=4 N=3 target=3 plus start in the same cycle -> three det_pulses -> done on the cycle after the third, hit_cnt=3.
REQ-043 cfg_m=0 -> cfg_err pulse, det_m stays 4, cfg_ready stays 1.
REQ-044 Window=20, no det_pulse -> timeout pulse exactly 20 ARMED cycles after arming, busy falls; final det_pulse on the expiry cycle -> done, no timeout.
REQ-045 Abort two cycles into ARMED with hit_cnt=1 -> IDLE next cycle, det_clr_n low one cycle, no done; a det_pulse in IDLE leaves hit_cnt at 1.
REQ-046 rst_n low mid-ARMED -> all outputs reach reset values asynchronously, no pulses on release.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequence-detector controller.
// The optional window timeout is enabled with the SEQ_CTRL_TIMEOUT_EN macro.
package seq_ctrl_pkg;

  localparam int M_W = 5;
  localparam int N_W = 6;

  localparam logic [M_W-1:0] DEF_M      = 5'd4;
  localparam logic [N_W-1:0] DEF_N      = 6'd3;
  localparam int             DEF_TARGET = 1;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    ARMED,
    DONE
  } state_t;

endpackage

// File: rtl/seq_win_timer.sv
// Down-counting detection-window timer; a load value of 0 leaves it disarmed.
// Built only when SEQ_CTRL_TIMEOUT_EN is defined.
module seq_win_timer #(
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIN_W-1:0] load_val,
  output logic             expired
);

  logic [WIN_W-1:0] cnt;

  // NOTE: asynchronous active-low reset in the sensitivity list; state updates use <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Fires on the enabled cycle that takes the count from 1 to 0.
  assign expired = enable && (cnt == WIN_W'(1));

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a serial M-of-N sequence detector: config capture, flush,
// arming, hit counting and done. Define SEQ_CTRL_TIMEOUT_EN for the window timeout.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8,
  parameter int WIN_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [M_W-1:0]   cfg_m,
  input  logic [N_W-1:0]   cfg_n,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             data_in,
  output logic             det_data,
  output logic             det_clr_n,
  output logic [M_W-1:0]   det_m,
  output logic [N_W-1:0]   det_n,
  input  logic             det_pulse,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             cfg_err,
  output logic [CNT_W-1:0] hit_cnt
);

  state_t           state;
  logic [3:0]       flush_cnt;
  logic [M_W-1:0]   m_q;
  logic [N_W-1:0]   n_q;
  logic [CNT_W-1:0] target_q;
  logic             clr_n_q;

  logic             cfg_fire;
  logic             cfg_bad;
  logic             cfg_ok;
  logic             run_start;
  logic [CNT_W-1:0] hit_inc;
  logic [CNT_W-1:0] target_eff;
  logic             final_hit;
  logic             expired;

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cfg_fire   = cfg_valid & cfg_ready;
  assign cfg_bad    = (cfg_m == '0) || (cfg_n == '0);
  assign cfg_ok     = cfg_fire & ~cfg_bad;
  assign run_start  = start & (state == IDLE);
  assign target_eff = (cfg_target == '0) ? CNT_W'(1) : cfg_target;
  assign hit_inc    = (hit_cnt == '1) ? hit_cnt : hit_cnt + 1'b1;
  assign final_hit  = det_pulse && (hit_inc >= target_q);

  assign det_data  = (state == ARMED) & data_in;
  assign det_clr_n = clr_n_q & (state != FLUSH);
  assign det_m     = m_q;
  assign det_n     = n_q;

`ifdef SEQ_CTRL_TIMEOUT_EN
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_load;

  // A config accepted alongside start must seed this run's window.
  assign win_load = cfg_ok ? cfg_window : win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '1;
    end else if (cfg_ok) begin
      win_q <= cfg_window;
    end
  end

  seq_win_timer #(.WIN_W(WIN_W)) u_win_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (run_start),
    .enable   (state == ARMED),
    .load_val (win_load),
    .expired  (expired)
  );
`else
  logic unused_window;
  assign unused_window = ^cfg_window;
  assign expired       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      m_q       <= DEF_M;
      n_q       <= DEF_N;
      target_q  <= CNT_W'(DEF_TARGET);
      hit_cnt   <= '0;
      clr_n_q   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle and the case has a default arm, so nothing holds stale values.
      done    <= 1'b0;
      timeout <= 1'b0;
      cfg_err <= cfg_fire & cfg_bad;
      clr_n_q <= 1'b1;

      if (cfg_ok) begin
        m_q      <= cfg_m;
        n_q      <= cfg_n;
        target_q <= target_eff;
      end

      // Abort outranks a coincident final hit or expiry.
      if (abort && state != IDLE) begin
        state   <= IDLE;
        clr_n_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= FLUSH;
              hit_cnt   <= '0;
              flush_cnt <= 4'(FLUSH_CYCLES - 1);
            end
          end
          FLUSH: begin
            if (flush_cnt == '0) state <= ARMED;
            else                 flush_cnt <= flush_cnt - 1'b1;
          end
          ARMED: begin
            if (det_pulse) hit_cnt <= hit_inc;
            if (final_hit) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (expired) begin
              state   <= IDLE;
              timeout <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
